// File: rtl/sdr_psk_pkg.sv
// Shared definitions for the PSK link: frame geometry, rx checker FSM states
// and a small saturating-increment helper.
package sdr_psk_pkg;

  // Frame length used by both the Tx framer and the Rx checker.
  localparam int FRAME_LEN_DEFAULT = 16;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_BODY = 1'b1
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_lock_filter.sv
// Hysteretic link-lock flag: LOCK_GOOD consecutive good frames assert
// locked, UNLOCK_BAD consecutive bad frames drop it.
module rx_lock_filter
  import sdr_psk_pkg::*;
#(
  parameter int LOCK_GOOD  = 4,
  parameter int UNLOCK_BAD = 3
) (
  input  logic clk_1M024,
  input  logic rst_1M024,
  input  logic frame_done,
  input  logic frame_ok,
  output logic locked
);

  localparam logic [8:0] GOOD_TH = 9'(LOCK_GOOD);
  localparam logic [8:0] BAD_TH  = 9'(UNLOCK_BAD);

  logic [7:0] good_run;
  logic [7:0] bad_run;
  logic [8:0] good_next;
  logic [8:0] bad_next;

  // Run length including the frame being reported this cycle.
  assign good_next = {1'b0, good_run} + 9'd1;
  assign bad_next  = {1'b0, bad_run} + 9'd1;

  always_ff @(posedge clk_1M024 or posedge rst_1M024) begin
    if (rst_1M024) begin
      good_run <= '0;
      bad_run  <= '0;
      locked   <= 1'b0;
    end else if (frame_done) begin
      if (frame_ok) begin
        good_run <= sat_inc8(good_run);
        bad_run  <= '0;
        if (good_next >= GOOD_TH) locked <= 1'b1;
      end else begin
        bad_run  <= sat_inc8(bad_run);
        good_run <= '0;
        if (bad_next >= BAD_TH) locked <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_frame_checker.sv
// Delimits received frames, checks them against the (seq + k) test pattern
// and keeps saturating quality counters plus a link-lock flag.
// Optional: define RX_CHECKER_SEQ_EN to add the lost_cnt sequence-gap counter.
module rx_frame_checker
  import sdr_psk_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEFAULT,
  parameter int CNT_W      = 16,
  parameter int LOCK_GOOD  = 4,
  parameter int UNLOCK_BAD = 3
) (
  input  logic             clk_1M024,
  input  logic             rst_1M024,
  input  logic [7:0]       data_tdata,
  input  logic             data_tvalid,
  input  logic             data_tuser,
  input  logic             data_tlast,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] byte_err_cnt,
  output logic [CNT_W-1:0] len_err_cnt,
`ifdef RX_CHECKER_SEQ_EN
  output logic [CNT_W-1:0] lost_cnt,
`endif
  output logic             locked
);

  localparam logic [8:0] LEN9 = 9'(FRAME_LEN);

  rx_state_e  state;
  logic [7:0] seq;
  logic [7:0] idx;
  logic       frame_err;

  logic [7:0] exp_byte;
  logic       mismatch;
  logic       in_body;
  logic       payload_beat;
  logic       body_end;
  logic       runt;
  logic       one_byte;
  logic       frame_end;
  logic       len_ok;
  logic       verdict;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign exp_byte     = seq + idx;
  assign mismatch     = data_tdata != exp_byte;
  assign in_body      = state == ST_BODY;
  assign payload_beat = data_tvalid & in_body & ~data_tuser;
  assign body_end     = payload_beat & data_tlast;
  assign runt         = data_tvalid & in_body & data_tuser;
  assign one_byte     = data_tvalid & ~in_body & data_tuser & data_tlast;
  assign frame_end    = body_end | runt | one_byte;
  // idx is the index of the current byte, so the frame length is idx+1.
  assign len_ok       = body_end & (({1'b0, idx} + 9'd1) == LEN9);
  assign verdict      = len_ok & ~frame_err & ~mismatch;

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk_1M024 or posedge rst_1M024) begin
    if (rst_1M024) begin
      state        <= ST_HUNT;
      seq          <= '0;
      idx          <= '0;
      frame_err    <= 1'b0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      frame_cnt    <= '0;
      good_cnt     <= '0;
      byte_err_cnt <= '0;
      len_err_cnt  <= '0;
    end else begin
      frame_done <= frame_end;
      frame_ok   <= verdict;
      if (frame_end)               frame_cnt    <= cnt_inc(frame_cnt);
      if (verdict)                 good_cnt     <= cnt_inc(good_cnt);
      if (frame_end & ~len_ok)     len_err_cnt  <= cnt_inc(len_err_cnt);
      if (payload_beat & mismatch) byte_err_cnt <= cnt_inc(byte_err_cnt);

      case (state)
        ST_HUNT: begin
          if (data_tvalid & data_tuser & ~data_tlast) begin
            state     <= ST_BODY;
            seq       <= data_tdata;
            idx       <= 8'd1;
            frame_err <= 1'b0;
          end
        end
        ST_BODY: begin
          if (data_tvalid) begin
            if (data_tuser) begin
              // Runt abort; the same beat opens the next frame. A tuser+tlast
              // beat here has no room for a second verdict and returns to HUNT.
              seq       <= data_tdata;
              idx       <= 8'd1;
              frame_err <= 1'b0;
              if (data_tlast) state <= ST_HUNT;
            end else begin
              if (mismatch)     frame_err <= 1'b1;
              if (idx != 8'hFF) idx       <= idx + 8'd1;
              if (data_tlast)   state     <= ST_HUNT;
            end
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

`ifdef RX_CHECKER_SEQ_EN
  localparam int SUM_W = CNT_W + 1;

  logic [7:0]       prev_seq;
  logic             prev_valid;
  logic             locked_d;
  logic             lock_drop;
  logic [7:0]       seq_gap;
  logic [CNT_W:0]   lost_sum;

  // lock_drop is high the cycle after locked falls, which is before any
  // later length-correct frame can complete.
  assign lock_drop = locked_d & ~locked;
  assign seq_gap   = seq - prev_seq - 8'd1;
  assign lost_sum  = {1'b0, lost_cnt} + SUM_W'(seq_gap);

  always_ff @(posedge clk_1M024 or posedge rst_1M024) begin
    if (rst_1M024) begin
      prev_seq   <= '0;
      prev_valid <= 1'b0;
      locked_d   <= 1'b0;
      lost_cnt   <= '0;
    end else begin
      locked_d <= locked;
      if (len_ok & prev_valid & ~lock_drop)
        lost_cnt <= lost_sum[CNT_W] ? '1 : lost_sum[CNT_W-1:0];
      if (verdict) begin
        prev_seq   <= seq;
        prev_valid <= 1'b1;
      end else if (lock_drop) begin
        prev_valid <= 1'b0;
      end
    end
  end
`endif

  rx_lock_filter #(
    .LOCK_GOOD (LOCK_GOOD),
    .UNLOCK_BAD(UNLOCK_BAD)
  ) u_lock_filter (
    .clk_1M024 (clk_1M024),
    .rst_1M024 (rst_1M024),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .locked    (locked)
  );

endmodule

// File: doc/rx_frame_checker.md
# rx_frame_checker

Downstream consumer of the receiver's recovered byte stream (`data_tdata/tvalid/tuser/tlast` at 1.024 MHz). It delimits frames, checks each against the transmitter's known test pattern, and keeps saturating quality counters and a hysteretic link-lock flag. Results are driven to ILA and GPIO for over-the-air BER and frame-loss measurement.

## Interface
Parameters:
- `FRAME_LEN`, 16: expected bytes per frame, including the sequence byte; legal range 2..255.
- `CNT_W`, 16: width of every statistics counter.
- `LOCK_GOOD`, 4: consecutive good frames needed to assert lock.
- `UNLOCK_BAD`, 3: consecutive bad frames needed to drop lock.

Ports:
- `clk_1M024` in 1: byte-stream clock.
- `rst_1M024` in 1: reset, asynchronous, active-high.
- `data_tdata` in 8: received byte.
- `data_tvalid` in 1: byte qualifier. No backpressure; the block must accept every valid beat.
- `data_tuser` in 1: start of frame, coincident with the sequence byte.
- `data_tlast` in 1: last byte of frame.
- `frame_done` out 1: one-cycle pulse per completed or aborted frame.
- `frame_ok` out 1: verdict for the frame, valid when `frame_done`=1.
- `frame_cnt` out CNT_W: frames completed or aborted.
- `good_cnt` out CNT_W: frames with correct length and zero byte errors.
- `byte_err_cnt` out CNT_W: mismatching payload bytes.
- `len_err_cnt` out CNT_W: frames with length ≠ FRAME_LEN.
- `lost_cnt` out CNT_W: frames missed per sequence gaps. Exists only with the macro.
- `locked` out 1: link-lock status.

## Operation
- FSM states:
  - HUNT: reset state. Ignore all beats until `tvalid & tuser`.
  - BODY: inside a frame.
- HUNT → BODY on `tvalid & tuser`:
  - latch `seq = tdata`
  - set `idx = 1`
  - clear the frame error flags.
- Expected payload byte at index k: `(seq + k) mod 256`, 8-bit wrap.
- In BODY, on each `tvalid` beat without `tuser`:
  - compare `tdata` with the expected byte; on mismatch, increment the per-frame error count and `byte_err_cnt`.
  - increment `idx`, saturating at 255.
- End of frame on `tvalid & tlast` in BODY:
  - length error if `idx+1 ≠ FRAME_LEN`.
  - `frame_ok` = no length error & zero byte errors.
  - next state HUNT.
- `tuser & tlast` on the same beat in HUNT: one-byte frame. Completes immediately as a length error, with no payload check; stays in HUNT.
- `tuser` while in BODY without `tlast` (runt):
  - abort the current frame: `frame_done`=1, `frame_ok`=0, `len_err_cnt`+1.
  - the same beat starts a new frame; remain in BODY.
- `tlast` seen in HUNT without `tuser`: ignored, no counters change.
- Bytes past FRAME_LEN are still compared; their mismatches count as byte errors.
- All counters saturate at 2^CNT_W−1 and never wrap.
- Lock filter:
  - good-run counter: clears on a bad frame, increments on a good frame.
  - `locked` sets when the good run reaches LOCK_GOOD.
  - bad-run counter: clears on a good frame.
  - `locked` clears when the bad run reaches UNLOCK_BAD.
- Reset at any time, including mid-frame, returns to HUNT. All outputs and counters go to 0, `locked`=0, and the partial frame is discarded uncounted.

## Timing
- Byte compare and `byte_err_cnt` update: registered, 1 cycle after the beat.
- `frame_done`, `frame_ok`, `frame_cnt`, `good_cnt` and `len_err_cnt`: all update in the same cycle, 1 cycle after the `tlast` (or runt `tuser`) beat.
- `locked` updates 1 cycle after `frame_done`.
- Back-to-back frames: the `tuser` beat may immediately follow the `tlast` beat with no idle cycle; throughput is 1 byte per cycle.
- Every output is registered and reset to 0.

## Configuration
- `RX_CHECKER_SEQ_EN` defined:
  - keep the last good frame's `seq`.
  - on each next length-correct frame, add `(seq_new − seq_prev − 1) mod 256` to `lost_cnt`, saturating.
  - the first frame after reset, or after `locked` falls, adds nothing.
- `RX_CHECKER_SEQ_EN` undefined: the `lost_cnt` port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `sdr_psk_pkg` holds:
  - FSM state encodings `ST_HUNT`, `ST_BODY`.
  - default `FRAME_LEN`, also used by the Tx framer.
- One sub-module, `rx_lock_filter`: the run counters and `locked` hysteresis. Inputs are `frame_done` and `frame_ok`.

## Test plan
- Five clean frames, FRAME_LEN=16, seq=0x10..0x14 → `good_cnt`=5, `byte_err_cnt`=0, `locked`=1 one cycle after the 4th `frame_done`.
- Frame with seq=0xFE; bytes k=2,3 expected 0x00,0x01 (wrap); byte 5 corrupted → `byte_err_cnt`=1, `frame_ok`=0, `good_cnt` unchanged.
- Runt: 7 bytes, then `tuser` of a clean 16-byte frame → `len_err_cnt`=1, `frame_cnt`=2, `good_cnt`=1.
- Locked link, 3 consecutive frames each with one bad byte → `locked` drops after the 3rd `frame_done`; 2 bad frames alone leave `locked`=1.
- With the macro, clean frames seq 0x20, 0x21, 0x25 → `lost_cnt`=3. With seq 0xFF then 0x01 → `lost_cnt`+1.
- Reset asserted at byte 8 of a frame, then released and a clean frame sent → all counters 0 after reset, then `frame_cnt`=1 and `good_cnt`=1.
